// File: rtl/tick_period_meter_pkg.sv
// Shared constants and state encoding for the tick period meter.
// The defaults match the game-speed clock dividers so both sides agree on rates.
package tick_period_meter_pkg;

   localparam int unsigned DEFAULT_CNT_W   = 30;
   localparam int unsigned DEFAULT_TIMEOUT = 20000000;
   localparam int unsigned DEFAULT_LOCK_N  = 2;

   // Width of the lock match counter; LOCK_N is at most 15.
   localparam int unsigned MATCH_W = 4;

   typedef enum logic [1:0] {
      StWaitEdge = 2'd0,
      StMeasure  = 2'd1,
      StStall    = 2'd2
   } meter_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop; reports single-cycle rise/fall strobes.
// Independent of the meter so it can be reused for button inputs.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   // Synchronise the asynchronous input, then keep one cycle of history.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= d;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign rise = s2_q & ~prev_q;
   assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Converts a slow square wave into a one-cycle tick enable and measures its
// period and high time in clk cycles, with lock and stall indication.
module tick_period_meter
   import tick_period_meter_pkg::*;
#(
   parameter int unsigned CNT_W   = DEFAULT_CNT_W,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned LOCK_N  = DEFAULT_LOCK_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic             tick,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             stalled
);

   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
   // Match count one short of lock: the next equal period asserts locked.
   localparam logic [MATCH_W-1:0] LOCK_PRE = MATCH_W'(LOCK_N - 1);
   localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_N);

   logic rise;
   logic fall;

   sync_edge_det u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in),
      .rise (rise),
      .fall (fall)
   );

   meter_state_e       state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   hlatch_q;
   logic [CNT_W-1:0]   period_q;
   logic [CNT_W-1:0]   high_time_q;
   logic [MATCH_W-1:0] match_q;
   logic               have_prev_q;
   logic               tick_q;
   logic               meas_valid_q;
   logic               locked_q;
   logic               stalled_q;

   logic [CNT_W-1:0]   cnt_inc;
   logic               period_match;

   // cnt counts from 0 after the reference edge, so cnt+1 is the elapsed cycle count.
   assign cnt_inc      = cnt_q + CNT_W'(1);
   // The first measurement after arming has no valid previous period.
   assign period_match = have_prev_q && (cnt_inc == period_q);

   // Measurement FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StWaitEdge;
         cnt_q        <= '0;
         hlatch_q     <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         match_q      <= '0;
         have_prev_q  <= 1'b0;
         tick_q       <= 1'b0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         tick_q       <= rise;
         meas_valid_q <= 1'b0;
         unique case (state_q)
            StWaitEdge: begin
               cnt_q <= '0;
               if (rise) begin
                  state_q     <= StMeasure;
                  hlatch_q    <= '0;
                  have_prev_q <= 1'b0;
               end
            end
            StMeasure: begin
               // A rise on the timeout cycle still completes the measurement.
               if (rise) begin
                  period_q     <= cnt_inc;
                  high_time_q  <= hlatch_q;
                  meas_valid_q <= 1'b1;
                  cnt_q        <= '0;
                  hlatch_q     <= '0;
                  have_prev_q  <= 1'b1;
                  if (period_match) begin
                     if (match_q < LOCK_MAX) begin
                        match_q <= match_q + MATCH_W'(1);
                     end
                     if (match_q >= LOCK_PRE) begin
                        locked_q <= 1'b1;
                     end
                  end else begin
                     match_q  <= '0;
                     locked_q <= 1'b0;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= StStall;
                  stalled_q <= 1'b1;
                  locked_q  <= 1'b0;
                  match_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
                  if (fall) begin
                     hlatch_q <= cnt_inc;
                  end
               end
            end
            StStall: begin
               // The first rise after a stall only re-arms the measurement.
               if (rise) begin
                  state_q     <= StMeasure;
                  stalled_q   <= 1'b0;
                  cnt_q       <= '0;
                  hlatch_q    <= '0;
                  have_prev_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StWaitEdge;
            end
         endcase
      end
   end

   assign tick       = tick_q;
   assign period     = period_q;
   assign high_time  = high_time_q;
   assign meas_valid = meas_valid_q;
   assign locked     = locked_q;
   assign stalled    = stalled_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Self-checking bench for tick_period_meter: table-driven waveform segments,
// hand-written latency/reset sequences, and random waveforms, all checked every
// cycle against a timestamp-based reference model.
module tb_tick_period_meter;

   localparam int CNT_W   = 30;
   localparam int TIMEOUT = 100;
   localparam int LOCK_N  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sig_in = 1'b0;
   logic             tick;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             stalled;

   always #5 clk = ~clk;

   tick_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .LOCK_N  (LOCK_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .tick       (tick),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .locked     (locked),
      .stalled    (stalled)
   );

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;
   int mv_cnt   = 0;
   int tick_cnt = 0;

   task automatic check(input string name, input logic [CNT_W-1:0] act,
                        input logic [CNT_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: works on timestamps of synchronised edges. A value sampled
   // at edge n becomes visible as an edge event at edge n+2.
   int m_n = 0;
   int h[$] = '{0, 0, 0, 0};
   bit m_armed, m_stalled, m_prev_ok, m_locked, e_tick, e_mv;
   int m_t0, m_hl, m_period, m_high, m_match;

   task automatic model_step();
      int p;
      bit r;
      bit f;
      m_n++;
      if (rst) begin
         h = '{0, 0, 0, 0};
         m_armed = 0; m_stalled = 0; m_prev_ok = 0; m_locked = 0;
         e_tick = 0; e_mv = 0;
         m_t0 = 0; m_hl = 0; m_period = 0; m_high = 0; m_match = 0;
      end else begin
         h.push_back(int'(sig_in));
         void'(h.pop_front());
         r = (h[1] == 1) && (h[0] == 0);
         f = (h[1] == 0) && (h[0] == 1);
         e_tick = r;
         e_mv   = 0;
         if (!m_armed) begin
            if (r) begin
               m_armed = 1; m_t0 = m_n; m_hl = 0; m_prev_ok = 0;
            end
         end else if (m_stalled) begin
            if (r) begin
               m_stalled = 0; m_t0 = m_n; m_hl = 0; m_prev_ok = 0;
            end
         end else if (r) begin
            p = m_n - m_t0;
            if (m_prev_ok && p == m_period) begin
               if (m_match < LOCK_N) m_match++;
               if (m_match >= LOCK_N) m_locked = 1;
            end else begin
               m_match = 0;
               m_locked = 0;
            end
            m_period = p; m_high = m_hl; e_mv = 1; m_prev_ok = 1;
            m_t0 = m_n; m_hl = 0;
         end else if (m_n - m_t0 == TIMEOUT) begin
            m_stalled = 1; m_locked = 0; m_match = 0;
         end else if (f) begin
            m_hl = m_n - m_t0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("cyc_tick", tick, e_tick);
         check("cyc_meas_valid", meas_valid, e_mv);
         check("cyc_period", period, CNT_W'(m_period));
         check("cyc_high_time", high_time, CNT_W'(m_high));
         check("cyc_locked", locked, m_locked);
         check("cyc_stalled", stalled, m_stalled);
      end
   end

   initial forever begin
      @(negedge clk);
      if (meas_valid === 1'b1) mv_cnt++;
      if (tick === 1'b1) tick_cnt++;
   end

   task automatic drive(input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         sig_in = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tick"}, tick, 0);
      check({tag, "_meas_valid"}, meas_valid, 0);
      check({tag, "_period"}, period, 0);
      check({tag, "_high_time"}, high_time, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_stalled"}, stalled, 0);
   endtask

   typedef struct {
      int hi;
      int lo;
      int reps;
      int exp_period;
      int exp_high;
      bit exp_locked;
      bit exp_stalled;
   } seg_t;

   seg_t segs[6];

   initial begin
      int mv0;
      int tk0;
      int hi;
      int lo;

      segs[0] = '{5, 5, 5, 10, 5, 1'b1, 1'b0};     // steady 10, lock on 3rd
      segs[1] = '{3, 17, 4, 20, 3, 1'b1, 1'b0};    // duty change, relock
      segs[2] = '{40, 60, 2, 100, 40, 1'b0, 1'b0}; // period exactly TIMEOUT
      segs[3] = '{10, 150, 1, 100, 40, 1'b0, 1'b1}; // source stalls
      segs[4] = '{5, 5, 1, 100, 40, 1'b0, 1'b0};   // arming edge only
      segs[5] = '{5, 5, 3, 10, 5, 1'b1, 1'b0};     // measurements resume

      rst = 1'b1;
      sig_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      chk_en = 1'b1;

      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < segs[s].reps; k++) begin
            drive(1'b1, segs[s].hi);
            drive(1'b0, segs[s].lo);
         end
         check($sformatf("seg%0d_period", s), period, CNT_W'(segs[s].exp_period));
         check($sformatf("seg%0d_high_time", s), high_time, CNT_W'(segs[s].exp_high));
         check($sformatf("seg%0d_locked", s), locked, segs[s].exp_locked);
         check($sformatf("seg%0d_stalled", s), stalled, segs[s].exp_stalled);
      end

      // Let the source stall, then measure rise-to-tick latency.
      drive(1'b0, 120);
      check("idle_stalled", stalled, 1);
      check("idle_locked", locked, 0);
      sig_in = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("latency_edge%0d", e), tick, (e == 3));
      end
      drive(1'b1, 6);
      drive(1'b0, 5);
      check("rearm_stalled", stalled, 0);

      // Reset in the middle of a measurement.
      drive(1'b1, 5);
      drive(1'b0, 5);
      drive(1'b1, 3);
      drive(1'b0, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all_zero("midrst");
      drive(1'b0, 3);
      mv0 = mv_cnt;
      tk0 = tick_cnt;
      drive(1'b1, 5);
      drive(1'b0, 5);
      check("midrst_arm_mv", CNT_W'(mv_cnt - mv0), 0);
      check("midrst_arm_tick", CNT_W'(tick_cnt - tk0), 1);
      drive(1'b1, 5);
      drive(1'b0, 5);
      check("midrst_meas_mv", CNT_W'(mv_cnt - mv0), 1);
      check("midrst_period", period, 10);
      check("midrst_high_time", high_time, 5);

      // Random waveforms, occasionally with a reset released while sig_in is high.
      for (int it = 0; it < 60; it++) begin
         hi = int'($urandom_range(2, 40));
         lo = int'($urandom_range(2, 90));
         if ($urandom_range(0, 9) == 0) begin
            sig_in = 1'b1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
         drive(1'b1, hi);
         drive(1'b0, lo);
      end
      drive(1'b0, 5);
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
